// File: rtl/switch_debouncer.sv
// Synchronizes and debounces the raw board switch into a clean level plus rise/fall strobes.
// Optional feature: define SWITCH_TOGGLE_EN to turn the output level into a press-toggled latch.
module switch_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic clock,
    input  logic isReset,
    input  logic rawSwitch,
    output logic switch,
    output logic switchRise,
    output logic switchFall
);

    localparam int unsigned COUNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam bit SINGLE_SAMPLE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        PEND_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        PEND_LOW    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;
    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   switch_d, rise_d, fall_d;

    // Synchronizer chain; the last flop feeds the debounce FSM.
    always_ff @(posedge clock) begin
        if (isReset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rawSwitch};
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    // State, qualification counter and registered outputs.
    always_ff @(posedge clock) begin
        if (isReset) begin
            state_q    <= STABLE_LOW;
            count_q    <= '0;
            switch     <= 1'b0;
            switchRise <= 1'b0;
            switchFall <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            switch     <= switch_d;
            switchRise <= rise_d;
            switchFall <= fall_d;
        end
    end

    // Next-state: any reversal during qualification restarts from zero.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        switch_d = switch;
        rise_d   = 1'b0;
        fall_d   = 1'b0;

        case (state_q)
            STABLE_LOW: begin
                if (sync_in && SINGLE_SAMPLE) begin
                    state_d = STABLE_HIGH;
                    count_d = '0;
                    rise_d  = 1'b1;
                end else if (sync_in) begin
                    state_d = PEND_HIGH;
                    count_d = COUNT_WIDTH'(1);
                end else begin
                    count_d = '0;
                end
            end
            PEND_HIGH: begin
                if (!sync_in) begin
                    state_d = STABLE_LOW;
                    count_d = '0;
                end else if (count_q == COUNT_LAST) begin
                    state_d = STABLE_HIGH;
                    count_d = '0;
                    rise_d  = 1'b1;
                end else begin
                    count_d = count_q + COUNT_WIDTH'(1);
                end
            end
            STABLE_HIGH: begin
                if (!sync_in && SINGLE_SAMPLE) begin
                    state_d = STABLE_LOW;
                    count_d = '0;
                    fall_d  = 1'b1;
                end else if (!sync_in) begin
                    state_d = PEND_LOW;
                    count_d = COUNT_WIDTH'(1);
                end else begin
                    count_d = '0;
                end
            end
            PEND_LOW: begin
                if (sync_in) begin
                    state_d = STABLE_HIGH;
                    count_d = '0;
                end else if (count_q == COUNT_LAST) begin
                    state_d = STABLE_LOW;
                    count_d = '0;
                    fall_d  = 1'b1;
                end else begin
                    count_d = count_q + COUNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = STABLE_LOW;
                count_d = '0;
            end
        endcase

`ifdef SWITCH_TOGGLE_EN
        // Latch mode: each accepted press flips the level, releases are ignored.
        if (rise_d) begin
            switch_d = ~switch;
        end
`else
        if (rise_d) begin
            switch_d = 1'b1;
        end else if (fall_d) begin
            switch_d = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer at default parameters (20 ns clock).
// Stimulus queues expected strobe events; a monitor matches them against DUT strobes.
module tb_switch_debouncer;

    localparam int unsigned LATENCY = 9;

    logic clock;
    logic isReset;
    logic rawSwitch;
    logic switch;
    logic switchRise;
    logic switchFall;

    typedef struct {
        int unsigned edge_no;
        logic        rise;
        logic        level;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned edge_cnt = 0;
    int          checks   = 0;
    int          errors   = 0;
    logic        exp_level = 1'b0;
    bit          done      = 1'b0;
    bit          quiet_chk = 1'b0;

    switch_debouncer dut (
        .clock      (clock),
        .isReset    (isReset),
        .rawSwitch  (rawSwitch),
        .switch     (switch),
        .switchRise (switchRise),
        .switchFall (switchFall)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    function automatic logic next_level(input logic rise, input logic cur);
`ifdef SWITCH_TOGGLE_EN
        return rise ? ~cur : cur;
`else
        return rise;
`endif
    endfunction

    // Drive a raw level before the next edge and hold it for 'cycles' edges.
    task automatic drive(input logic v, input int cycles, input bit qual);
        int unsigned start;
        ev_t e;
        @(negedge clock);
        rawSwitch = v;
        start = edge_cnt + 1;
        if (qual) begin
            exp_level = next_level(v, exp_level);
            e.edge_no = start + LATENCY;
            e.rise    = v;
            e.level   = exp_level;
            exp_q.push_back(e);
        end
        repeat (cycles) @(posedge clock);
    endtask

    // Stimulus
    initial begin
        ev_t e;
        isReset   = 1'b1;
        rawSwitch = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        isReset = 1'b0;
        exp_level = next_level(1'b1, exp_level);
        e.edge_no = edge_cnt + 1 + LATENCY;
        e.rise    = 1'b1;
        e.level   = exp_level;
        exp_q.push_back(e);
        repeat (15) @(posedge clock);

        drive(1'b0, 15, 1'b1);
        drive(1'b1, 15, 1'b1);
        drive(1'b0, 15, 1'b1);
        // bounce, then settle high
        drive(1'b1, 2, 1'b0);
        drive(1'b0, 2, 1'b0);
        drive(1'b1, 2, 1'b0);
        drive(1'b0, 2, 1'b0);
        drive(1'b1, 15, 1'b1);
        drive(1'b0, 15, 1'b1);
        // 7-cycle glitch is rejected, 8-cycle level is accepted
        drive(1'b1, 7, 1'b0);
        drive(1'b0, 15, 1'b0);
        drive(1'b1, 8, 1'b1);
        drive(1'b0, 20, 1'b1);

        repeat (3) @(posedge clock);
        done = 1'b1;
    end

    // Monitor and scoreboard
    always @(posedge clock) begin
        ev_t got;
        #1;
        if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_events: %0d still pending, required 0 (next at edge %0d)",
                         exp_q.size(), exp_q[0].edge_no);
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end else if (isReset) begin
            checks += 3;
            if (switch !== 1'b0) begin
                errors++;
                $display("FAIL reset_switch edge %0d: got %b required 0", edge_cnt, switch);
            end
            if (switchRise !== 1'b0) begin
                errors++;
                $display("FAIL reset_rise edge %0d: got %b required 0", edge_cnt, switchRise);
            end
            if (switchFall !== 1'b0) begin
                errors++;
                $display("FAIL reset_fall edge %0d: got %b required 0", edge_cnt, switchFall);
            end
        end else if (quiet_chk) begin
            quiet_chk = 1'b0;
            checks++;
            if (switchRise !== 1'b0 || switchFall !== 1'b0) begin
                errors++;
                $display("FAIL strobe_width edge %0d: rise=%b fall=%b required both 0",
                         edge_cnt, switchRise, switchFall);
            end
        end else if (switchRise !== 1'b0 || switchFall !== 1'b0) begin
            quiet_chk = 1'b1;
            checks++;
            if (switchRise === 1'b1 && switchFall === 1'b1) begin
                errors++;
                $display("FAIL both_strobes edge %0d: rise=1 fall=1 required at most one", edge_cnt);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe edge %0d: rise=%b fall=%b required none",
                         edge_cnt, switchRise, switchFall);
            end else begin
                got = exp_q.pop_front();
                checks += 2;
                if (edge_cnt != got.edge_no || switchRise !== got.rise) begin
                    errors++;
                    $display("FAIL strobe_timing: got rise=%b at edge %0d, required rise=%b at edge %0d",
                             switchRise, edge_cnt, got.rise, got.edge_no);
                end
                if (switch !== got.level) begin
                    errors++;
                    $display("FAIL switch_level edge %0d: got %b required %b",
                             edge_cnt, switch, got.level);
                end
            end
        end
    end

endmodule
